// File: rtl/act_lut_loader.sv
// act_lut_loader: sequences coefficient words from the main-memory stream
// into one slot of the activation-function lookup table, and holds
// evaluation traffic off the table until the rewrite has finished.
module act_lut_loader #(
    parameter  int ACT_MASK_SIZE = 4,
    parameter  int ACT_LUT_DEPTH = 5,
    parameter  int MM_WIDTH      = 32,
    localparam int AW            = ACT_MASK_SIZE + ACT_LUT_DEPTH + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    // load command
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ACT_MASK_SIZE-1:0] cmd_mask,
    input  logic [ACT_LUT_DEPTH:0]   cmd_start,
    input  logic [ACT_LUT_DEPTH+1:0] cmd_count,
    // coefficient word stream
    input  logic                     data_valid,
    output logic                     data_ready,
    input  logic [MM_WIDTH-1:0]      data_in,
    // evaluation request gate
    input  logic                     eval_valid_in,
    output logic                     eval_ready_out,
    output logic                     eval_valid_out,
    input  logic                     eval_ready_in,
    // table write port
    output logic                     write_enable,
    output logic [AW-1:0]            write_addr,
    output logic [MM_WIDTH-1:0]      write_data,
    // status
    output logic                     busy,
    output logic                     done
);

    localparam int IW = ACT_LUT_DEPTH + 1;  // word index width within a slot
    localparam int CW = ACT_LUT_DEPTH + 2;  // word count width (0..2^IW)
    localparam logic [CW-1:0] MAX_WORDS = CW'(2 ** IW);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_LOAD,
        ST_DONE
    } state_e;

    state_e                   state_q;
    logic [ACT_MASK_SIZE-1:0] mask_q;
    logic [IW-1:0]            index_q;
    logic [CW-1:0]            remaining_q;
    logic                     write_enable_q;
    logic [AW-1:0]            write_addr_q;
    logic [MM_WIDTH-1:0]      write_data_q;

    logic [CW-1:0]            count_clamped;

    // Oversized requests can write at most one full slot.
    assign count_clamped = (cmd_count > MAX_WORDS) ? MAX_WORDS : cmd_count;

    // Load sequencer: command latch, drain, word-by-word write, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            mask_q         <= '0;
            index_q        <= '0;
            remaining_q    <= '0;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
        end else begin
            // NOTE: every state register here uses <= so all of them see the
            // pre-edge values; a blocking '=' would let later lines observe
            // the already-updated index/remaining within the same edge.
            write_enable_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        mask_q      <= cmd_mask;
                        index_q     <= cmd_start;
                        remaining_q <= count_clamped;
                        state_q     <= ST_DRAIN;
                    end
                end
                // One quiet cycle lets a read issued alongside the accepted
                // command complete before the first write lands.
                ST_DRAIN: begin
                    state_q <= (remaining_q == '0) ? ST_DONE : ST_LOAD;
                end
                ST_LOAD: begin
                    if (data_valid) begin
                        write_enable_q <= 1'b1;
                        write_addr_q   <= {mask_q, index_q};
                        write_data_q   <= data_in;
                        // Index wraps inside the slot; the mask field is
                        // held separately so it can never be carried into.
                        index_q        <= index_q + IW'(1);
                        remaining_q    <= remaining_q - CW'(1);
                        if (remaining_q == CW'(1)) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshakes and status decode straight from the state register.
    assign busy       = (state_q != ST_IDLE);
    assign cmd_ready  = (state_q == ST_IDLE);
    assign data_ready = (state_q == ST_LOAD);
    assign done       = (state_q == ST_DONE);

    // Evaluation traffic passes through only while the table is stable.
    assign eval_valid_out = eval_valid_in & ~busy;
    assign eval_ready_out = eval_ready_in & ~busy;

    assign write_enable = write_enable_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;

endmodule
